// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator for a registered magnitude comparator.
// It drives probe values on `a`, samples the great/less/equal flags and converges on the unknown `b`.
module cmp_search_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CMP_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [WIDTH-1:0]           probe,
    input  logic                       great,
    input  logic                       less,
    input  logic                       equal,
    output logic                       busy,
    output logic                       done,
    output logic                       hit,
    output logic                       err,
    output logic [WIDTH-1:0]           result,
    output logic [$clog2(WIDTH+2)-1:0] steps
);

    localparam int unsigned STEPS_W = $clog2(WIDTH + 2);
    localparam int unsigned CNT_W   = $clog2(CMP_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EVAL,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   probe_q, probe_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STEPS_W-1:0] steps_q, steps_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hit_q, hit_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Midpoint computed one bit wider so lo+hi cannot overflow.
    function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h);
        logic [WIDTH:0] sum;
        sum = {1'b0, l} + {1'b0, h};
        return sum[WIDTH:1];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            probe_q  <= '0;
            cnt_q    <= '0;
            steps_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            cnt_q    <= cnt_d;
            steps_q  <= steps_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        cnt_d    = cnt_q;
        steps_d  = steps_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hit_d    = hit_q;
        err_d    = err_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = '1;
                    probe_d = mid('0, '1);
                    steps_d = STEPS_W'(1);
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = CNT_W'(CMP_LAT);
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end

            // Hold the probe until the comparator flags reflect it.
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_EVAL;
                end
            end

            S_EVAL: begin
                result_d = probe_q;
                case ({great, less, equal})
                    3'b001: begin
                        hit_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end
                    3'b100: begin
                        if (probe_q == lo_q) begin
                            err_d   = 1'b1;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_FIN;
                        end else begin
                            hi_d    = probe_q - WIDTH'(1);
                            probe_d = mid(lo_q, probe_q - WIDTH'(1));
                            steps_d = steps_q + STEPS_W'(1);
                            cnt_d   = CNT_W'(CMP_LAT);
                            state_d = S_WAIT;
                        end
                    end
                    3'b010: begin
                        if (probe_q == hi_q) begin
                            err_d   = 1'b1;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_FIN;
                        end else begin
                            lo_d    = probe_q + WIDTH'(1);
                            probe_d = mid(probe_q + WIDTH'(1), hi_q);
                            steps_d = steps_q + STEPS_W'(1);
                            cnt_d   = CNT_W'(CMP_LAT);
                            state_d = S_WAIT;
                        end
                    end
                    default: begin
                        hit_d   = 1'b0;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end
                endcase
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign probe  = probe_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign hit    = hit_q;
    assign err    = err_q;
    assign result = result_q;
    assign steps  = steps_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Scoreboard bench for cmp_search_ctrl: a 16-bit/latency-1 instance and an 8-bit/latency-3 instance,
// each closed-loop against a behavioural registered comparator.
module tb_cmp_search_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int unsigned hit;
        int unsigned err;
        int unsigned result;
        int unsigned steps;
        int unsigned lat;
        int          t0;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    // 16-bit instance, CMP_LAT=1
    logic        rst16, start16, great16, less16, equal16;
    logic        busy16, done16, hit16, err16;
    logic [15:0] probe16, result16, b16, a16_q;
    logic [4:0]  steps16;
    bit          force_bad;

    cmp_search_ctrl #(.WIDTH(16), .CMP_LAT(1)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .probe(probe16),
        .great(great16), .less(less16), .equal(equal16),
        .busy(busy16), .done(done16), .hit(hit16), .err(err16),
        .result(result16), .steps(steps16)
    );

    always @(posedge clk) a16_q <= probe16;
    always_comb begin
        if (force_bad) begin
            great16 = 1'b1;
            less16  = 1'b1;
            equal16 = 1'b0;
        end else begin
            great16 = a16_q > b16;
            less16  = a16_q < b16;
            equal16 = a16_q == b16;
        end
    end

    // 8-bit instance, CMP_LAT=3
    logic       rst8, start8, great8, less8, equal8;
    logic       busy8, done8, hit8, err8;
    logic [7:0] probe8, result8, b8;
    logic [7:0] a8_p [3];
    logic [3:0] steps8;

    cmp_search_ctrl #(.WIDTH(8), .CMP_LAT(3)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .probe(probe8),
        .great(great8), .less(less8), .equal(equal8),
        .busy(busy8), .done(done8), .hit(hit8), .err(err8),
        .result(result8), .steps(steps8)
    );

    always @(posedge clk) begin
        a8_p[0] <= probe8;
        a8_p[1] <= a8_p[0];
        a8_p[2] <= a8_p[1];
    end
    assign great8 = a8_p[2] > b8;
    assign less8  = a8_p[2] < b8;
    assign equal8 = a8_p[2] == b8;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop the expected response whenever a done pulse appears.
    always @(negedge clk) begin : mon16
        exp_t e;
        if (done16) begin
            if (q16.size() == 0) begin
                chk("unexpected_done16", 1, 0);
            end else begin
                e = q16.pop_front();
                chk("hit16", hit16, e.hit);
                chk("err16", err16, e.err);
                chk("result16", result16, e.result);
                chk("steps16", steps16, e.steps);
                chk("latency16", int'(cyc - e.t0), e.lat);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("hit8", hit8, e.hit);
                chk("err8", err8, e.err);
                chk("result8", result8, e.result);
                chk("steps8", steps8, e.steps);
                chk("latency8", int'(cyc - e.t0), e.lat);
            end
        end
    end

    task automatic go16(input logic [15:0] b, input int unsigned h, input int unsigned e,
                        input int unsigned res, input int unsigned st, input int unsigned lat);
        exp_t x;
        x.hit = h; x.err = e; x.result = res; x.steps = st; x.lat = lat; x.t0 = cyc;
        b16 = b;
        q16.push_back(x);
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic go8(input logic [7:0] b, input int unsigned h, input int unsigned e,
                       input int unsigned res, input int unsigned st, input int unsigned lat);
        exp_t x;
        x.hit = h; x.err = e; x.result = res; x.steps = st; x.lat = lat; x.t0 = cyc;
        b8 = b;
        q8.push_back(x);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done16();
        int n = 0;
        do begin @(negedge clk); n++; end while (!done16 && n < 300);
        chk("done16_seen", done16, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_done8();
        int n = 0;
        do begin @(negedge clk); n++; end while (!done8 && n < 300);
        chk("done8_seen", done8, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_zero16(input string tag);
        chk({tag, "_probe"}, probe16, 0);
        chk({tag, "_busy"}, busy16, 0);
        chk({tag, "_done"}, done16, 0);
        chk({tag, "_hit"}, hit16, 0);
        chk({tag, "_err"}, err16, 0);
        chk({tag, "_result"}, result16, 0);
        chk({tag, "_steps"}, steps16, 0);
    endtask

    initial begin
        rst16 = 1'b1; rst8 = 1'b1;
        start16 = 1'b0; start8 = 1'b0;
        b16 = '0; b8 = '0; force_bad = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero16("reset16");
        chk("reset8_probe", probe8, 0);
        chk("reset8_busy", busy8, 0);
        chk("reset8_steps", steps8, 0);
        rst16 = 1'b0; rst8 = 1'b0;
        @(posedge clk); #1;

        // Immediate hit at the first midpoint
        go16(16'h7FFF, 1, 0, 16'h7FFF, 1, 3);
        chk("t1_probe", probe16, 16'h7FFF);
        chk("t1_busy", busy16, 1);
        wait_done16();

        // Lower bound, upper bound (no wrap)
        go16(16'h0000, 1, 0, 16'h0000, 16, 33);
        wait_done16();
        go16(16'hFFFF, 1, 0, 16'hFFFF, 17, 35);
        wait_done16();
        chk("t3_probe_held", probe16, 16'hFFFF);

        // Illegal flag combination on the first evaluation
        force_bad = 1'b1;
        go16(16'h7FFF, 0, 1, 16'h7FFF, 1, 3);
        wait_done16();
        force_bad = 1'b0;

        // Inconsistent comparator: b jumps below the searched window after the first answer
        go16(16'hFFFF, 0, 1, 16'h8000, 16, 33);
        begin
            int n = 0;
            while (probe16 == 16'h7FFF && n < 20) begin @(posedge clk); #1; n++; end
        end
        chk("t4_second_probe", probe16, 16'hBFFF);
        b16 = 16'h0005;
        wait_done16();

        // Start pulses while busy must be ignored
        go16(16'h0000, 1, 0, 16'h0000, 16, 33);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 start16 = 1'b1;
            @(posedge clk); #1 start16 = 1'b0;
        end
        wait_done16();

        // Reset in the middle of a search: outputs clear, no done pulse
        b16 = 16'h1234;
        start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("t6_busy_before_rst", busy16, 1);
        rst16 = 1'b1;
        @(posedge clk); #1;
        chk_zero16("midrst16");
        rst16 = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Fresh search after the aborted one
        go16(16'h0005, 1, 0, 16'h0005, 15, 31);
        wait_done16();

        // 8-bit, latency-3 comparator: 4 cycles per probe
        go8(8'h0A, 1, 0, 8'h0A, 8, 33);
        chk("t5_probe", probe8, 8'h7F);
        wait_done8();

        repeat (5) @(posedge clk);
        chk("q16_drained", q16.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_search_ctrl.md
Name: cmp_search_ctrl

Overview:
- Initiator-side counterpart of the registered 16-bit magnitude comparator (a, b, great/less/equal).
- Drives the comparator's `a` input with probe values and consumes its `great`/`less`/`equal` flags.
- Binary-searches for the unknown value on the comparator's `b` input.
- Reports the found value, the probe count and error status. Used for threshold/calibration search and as a closed-loop exerciser for the comparator.

Parameters:
- WIDTH, 16, data width of probe and result (matches comparator `a`/`b`).
- CMP_LAT, 1, comparator latency in clock cycles from `a` change to valid flags (minimum 1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a search; ignored unless idle.
- probe  output  WIDTH  value driven to comparator `a`; registered.
- great  input  1  comparator flag: probe > unknown.
- less  input  1  comparator flag: probe < unknown.
- equal  input  1  comparator flag: probe == unknown.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse at search end.
- hit  output  1  valid with done and held until next start: 1 = match found.
- err  output  1  valid with done and held until next start: 1 = illegal flag combination or bounds crossed.
- result  output  WIDTH  matched value (hit=1) or last probe (hit=0); held until next start.
- steps  output  $clog2(WIDTH+2)  number of probes issued in the last search; held.

Behaviour:
- Reset (rst=1 at a rising edge, any state):
  - state=IDLE; probe=0, busy=0, done=0, hit=0, err=0, result=0, steps=0.
  - Reset mid-search aborts the search with no done pulse.
- States: IDLE, WAIT, EVAL, FIN.
- IDLE, start=1:
  - lo=0, hi=2^WIDTH-1, probe=(lo+hi)>>1 computed at WIDTH+1 bits (no overflow).
  - steps=1, hit=0, err=0, wait counter=CMP_LAT, busy=1, go to WAIT.
- WAIT: decrement counter each cycle; when counter reaches 0, go to EVAL.
  - Flags are therefore sampled CMP_LAT+1 edges after the probe change.
- EVAL: samples flags exactly once per probe.
  - Exactly one flag set, equal=1: hit=1, result=probe, go to FIN.
  - Exactly one flag set, great=1:
    - If probe==lo: err=1, result=probe, go to FIN (bounds crossed).
    - Else hi=probe-1.
  - Exactly one flag set, less=1:
    - If probe==hi: err=1, result=probe, go to FIN.
    - Else lo=probe+1.
  - Search continues (great/less without error): probe=(lo+hi)>>1 using the updated bounds, steps+=1, counter=CMP_LAT, go to WAIT.
  - Zero or more than one flag set: err=1, hit=0, result=probe, go to FIN.
- FIN: done=1 for exactly this cycle, busy=0; next cycle IDLE.
  - hit/err/result/steps stay stable until the next accepted start.
- start while busy or in FIN is ignored, with no effect on the running search.
- start in the same cycle as rst: reset wins.
- Probe count never exceeds WIDTH+1 for a stable, consistent comparator. Cycles per probe = CMP_LAT+1.
- probe holds its last value after done. It changes only on start or in EVAL.
- Unsigned arithmetic throughout. lo/hi are WIDTH bits. probe-1 is never evaluated at probe==lo, and probe+1 is never evaluated at probe==hi, so no wrap-around can occur.

Test Plan:
1. Comparator model with b=0x7FFF, CMP_LAT=1, pulse start:
   - probe=0x7FFF one cycle later.
   - done 3 cycles after start; hit=1, result=0x7FFF, steps=1, err=0.
2. b=0x0000:
   - Probes 0x7FFF, 0x3FFF, 0x1FFF, … down to 0x0000.
   - hit=1, result=0x0000, steps=16, err=0.
   - done exactly 16*2+1 cycles after start.
3. b=0xFFFF:
   - Last probe 0xFFFF; hit=1, result=0xFFFF, steps=17, err=0; no wrap to 0x0000.
4. Bench forces great=1 and less=1 on the first EVAL:
   - done with err=1, hit=0, result=0x7FFF, steps=1.
   - Then b changes to 0x0005 mid-search, forcing inconsistent answers: err=1 when bounds cross.
5. b=0x0A with CMP_LAT=3 and WIDTH=8:
   - 4 cycles per probe; hit=1, result=0x0A; flags never sampled before 4 edges after a probe change.
6. Control robustness:
   - start pulses while busy: search unaffected, steps unchanged.
   - rst asserted mid-WAIT: next cycle all outputs 0, no done pulse.
   - New start after reset completes normally (b=0x0005 → result=0x0005).
